// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter feeding one register-file write port,
// with a pending-write scoreboard that flags read-after-write hazards.
module regfile_wb_arbiter #(
  parameter int PRIO_RESET = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rw,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rw,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        rsv_en,
  input  logic [4:0]  rsv_rw,
  input  logic [4:0]  rd_ra,
  input  logic [4:0]  rd_rb,
  output logic        hazard_a,
  output logic        hazard_b,
  output logic        wEn,
  output logic [4:0]  RW,
  output logic [31:0] busW,
  output logic [31:0] pending
);

  localparam logic PRIO_INIT = (PRIO_RESET != 0);

  logic        prio_q, prio_d;
  logic        wen_q, wen_d;
  logic [4:0]  rw_q, rw_d;
  logic [31:0] busw_q, busw_d;
  logic [31:0] pend_q, pend_d;

  logic        gnt0, gnt1, xfer;
  logic [4:0]  xfer_rw;
  logic [31:0] xfer_data;
  logic [31:0] set_mask, clr_mask;

  // Grants see only the valids and the pointer; reset gates them off at once.
  always_comb begin
    gnt0 = reset & req0_valid & (~req1_valid | ~prio_q);
    gnt1 = reset & req1_valid & (~req0_valid |  prio_q);
    xfer = gnt0 | gnt1;
    xfer_rw   = gnt1 ? req1_rw   : req0_rw;
    xfer_data = gnt1 ? req1_data : req0_data;
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0)
      prio_d = 1'b1;
    else if (gnt1)
      prio_d = 1'b0;

    wen_d  = xfer & (xfer_rw != 5'd0);
    rw_d   = rw_q;
    busw_d = busw_q;
    if (xfer) begin
      rw_d   = xfer_rw;
      busw_d = xfer_data;
    end

    set_mask = '0;
    clr_mask = '0;
    if (rsv_en && rsv_rw != 5'd0)
      set_mask = 32'd1 << rsv_rw;
    if (xfer && xfer_rw != 5'd0)
      clr_mask = 32'd1 << xfer_rw;
    // Applying the set after the clear lets a same-edge reservation win.
    pend_d    = (pend_q & ~clr_mask) | set_mask;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= PRIO_INIT;
      wen_q  <= 1'b0;
      rw_q   <= 5'd0;
      busw_q <= 32'd0;
      pend_q <= 32'd0;
    end else begin
      prio_q <= prio_d;
      wen_q  <= wen_d;
      rw_q   <= rw_d;
      busw_q <= busw_d;
      pend_q <= pend_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign wEn        = wen_q;
  assign RW         = rw_q;
  assign busW       = busw_q;
  assign pending    = pend_q;
  assign hazard_a   = pend_q[rd_ra];
  assign hazard_b   = pend_q[rd_rb];

endmodule
